cmd_mem_loader: RTL and testbench
=================================

Name: cmd_mem_loader

Overview:
- Writer-side front end for the processor command memory.
- Accepts a narrow valid/ready beat stream from the host or DMA and packs beats into full-width commands.
- Drives the memory write port: write_enable, write_address, cmd_in.
- Loads a programmed count of commands starting at a base address, then reports done or a framing error.

Parameters:
- CMD_WIDTH, 128: command word width; must equal the command memory width.
- ADDR_WIDTH, 8: command memory address width.
- BUS_WIDTH, 32: input beat width. CMD_WIDTH must be an integer multiple of BUS_WIDTH, checked at elaboration.
- Derived: WORDS_PER_CMD = CMD_WIDTH/BUS_WIDTH (default 4).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first write address; sampled on start
- num_cmds  in  ADDR_WIDTH+1  number of commands to load (0..2^ADDR_WIDTH); sampled on start
- s_data  in  BUS_WIDTH  input beat
- s_valid  in  1  beat valid
- s_last  in  1  marks the final beat of the load
- s_ready  out  1  beat accept
- write_enable  out  1  memory write strobe
- write_address  out  ADDR_WIDTH  memory write address
- cmd_in  out  CMD_WIDTH  assembled command
- busy  out  1  high while in LOAD
- done  out  1  one-cycle pulse at end of load
- error  out  1  sticky framing error; cleared on next accepted start

Behaviour:
- Reset values: all outputs 0; state IDLE; beat, command and address counters 0.
- A beat is accepted on the rising edge where s_valid && s_ready.
- IDLE:
  - start with num_cmds != 0: go to LOAD, latch base_addr and num_cmds, clear error.
  - start with num_cmds == 0: no transfer; done pulses next cycle; error cleared; stay in IDLE.
  - start while in LOAD: ignored.
- LOAD:
  - s_ready = 1 continuously, so throughput is one beat per cycle with no bubbles between commands.
  - Beat k of a command (k = 0..WORDS_PER_CMD-1) fills cmd bits [k*BUS_WIDTH +: BUS_WIDTH]; first beat goes to the LSBs.
  - Accepting the last beat of a command at edge N gives, during cycle N+1: write_enable = 1, write_address = current address, cmd_in = assembled word.
  - write_enable is a single-cycle pulse per command. cmd_in and write_address hold their values until the next write.
  - Address increments by 1 after each write and wraps modulo 2^ADDR_WIDTH (e.g. base 0xFE, 4 commands writes 0xFE, 0xFF, 0x00, 0x01).
  - The beat that completes the final command returns the state to IDLE. Cycle N+1 then has: final write_enable, done = 1, busy = 0, s_ready = 0.
- Framing:
  - Required: s_last == 1 exactly on the final beat of the final command.
  - s_last on any earlier beat: that beat is accepted but its partial command is discarded (no write). Go to IDLE with error = 1 and a done pulse.
  - Final beat arrives without s_last: the final write still occurs, then error = 1 with done.
- Reset asserted mid-load: immediate return to IDLE and outputs to reset values. No partial write is ever issued.
- done and error are registered outputs.

Optional Feature:
- Macro: CMD_MEM_LOADER_CHECKSUM_EN.
- With macro: adds output port checksum, width CMD_WIDTH.
  - checksum = running XOR of all commands written in the current load.
  - Cleared on accepted start; updated in the same cycle as each write_enable; stable from the done pulse until the next start.
- Without macro: port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic load: base_addr = 0x10, num_cmds = 2, beats 0x1..0x8 with s_last on beat 8 -> two writes:
  - addr 0x10, cmd 0x00000004_00000003_00000002_00000001
  - addr 0x11, cmd 0x00000008_00000007_00000006_00000005
  - done pulses on the second write cycle; error = 0.
- Wrap-around: base_addr = 0xFE, num_cmds = 4, continuous valid -> writes to 0xFE, 0xFF, 0x00, 0x01; s_ready never drops before the final beat.
- Backpressure gaps: s_valid toggled randomly -> identical write contents and addresses as a gapless run; write_enable only in the cycle after each 4th accepted beat.
- Early s_last on beat 6 of a 3-command load -> exactly one write (addr base); error = 1 and done pulse; next start with num_cmds = 1 clears error.
- Edge cases:
  - num_cmds = 0 -> done pulse the cycle after start, no write_enable.
  - start while busy -> ignored.
  - rst_n low after beat 2 -> no write, busy = 0.
- With CMD_MEM_LOADER_CHECKSUM_EN, basic-load data -> checksum = 0x0000000C_00000004_00000004_00000004 at done.

Source files
------------

// File: rtl/cmd_mem_loader.sv
// cmd_mem_loader: packs valid/ready beats into commands and writes them to command memory
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, base_addr,
//   num_cmds             : load request (sampled in IDLE)
//   s_data, s_valid,
//   s_last, s_ready      : input beat stream, first beat lands in the command LSBs
//   write_enable,
//   write_address, cmd_in: command memory write port
//   busy, done, error    : status (done pulse, sticky framing error)
//   checksum             : XOR of written commands, only with CMD_MEM_LOADER_CHECKSUM_EN
module cmd_mem_loader #(
  parameter int CMD_WIDTH  = 128,
  parameter int ADDR_WIDTH = 8,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_cmds,
  input  logic [BUS_WIDTH-1:0]  s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [CMD_WIDTH-1:0]  cmd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  error
`ifdef CMD_MEM_LOADER_CHECKSUM_EN
  ,
  output logic [CMD_WIDTH-1:0]  checksum
`endif
);
  localparam int WORDS = CMD_WIDTH / BUS_WIDTH;
  localparam int BW = WORDS > 1 ? $clog2(WORDS) : 1;
  if (CMD_WIDTH % BUS_WIDTH != 0 || WORDS < 1) begin : g_bad_width
    $error("CMD_WIDTH must be a non-zero integer multiple of BUS_WIDTH");
  end
  typedef enum logic {IDLE, LOAD} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q;
  logic [ADDR_WIDTH:0] left_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CMD_WIDTH-1:0] asm_q, asm_d;
  logic accept, last_beat, final_cmd, end_load, wr;
  assign s_ready = state_q == LOAD;
  assign busy = state_q == LOAD;
  assign accept = s_valid && s_ready;
  assign last_beat = beat_q == BW'(WORDS - 1);
  assign final_cmd = left_q == (ADDR_WIDTH + 1)'(1);
  // An early s_last ends the load and drops the partial command; the final beat always writes.
  assign end_load = accept && ((last_beat && final_cmd) || s_last);
  assign wr = accept && last_beat && (final_cmd || !s_last);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = (state_q == IDLE && start && |num_cmds) ? LOAD :
              (state_q == LOAD && end_load) ? IDLE : state_q;
    asm_d = asm_q;
    for (int k = 0; k < WORDS; k++)
      if (beat_q == BW'(k)) asm_d[k*BUS_WIDTH +: BUS_WIDTH] = s_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      left_q <= '0;
      addr_q <= '0;
      asm_q <= '0;
      write_enable <= 1'b0;
      write_address <= '0;
      cmd_in <= '0;
      done <= 1'b0;
      error <= 1'b0;
`ifdef CMD_MEM_LOADER_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      write_enable <= wr;
      done <= 1'b0;
      if (state_q == IDLE && start) begin
        done <= ~|num_cmds;
        error <= 1'b0;
        addr_q <= base_addr;
        left_q <= num_cmds;
        beat_q <= '0;
`ifdef CMD_MEM_LOADER_CHECKSUM_EN
        checksum <= '0;
`endif
      end
      if (accept) begin
        asm_q <= asm_d;
        beat_q <= last_beat ? '0 : beat_q + 1'b1;
      end
      if (wr) begin
        cmd_in <= asm_d;
        write_address <= addr_q;
        addr_q <= addr_q + 1'b1;
        left_q <= left_q - 1'b1;
`ifdef CMD_MEM_LOADER_CHECKSUM_EN
        checksum <= checksum ^ asm_d;
`endif
      end
      if (end_load) begin
        done <= 1'b1;
        error <= !(last_beat && final_cmd && s_last);
        beat_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_cmd_mem_loader.sv
// tb_cmd_mem_loader: directed scoreboard bench for cmd_mem_loader
module tb_cmd_mem_loader;
  logic clk = 0;
  logic rst_n;
  logic start;
  logic [7:0] base_addr;
  logic [8:0] num_cmds;
  logic [31:0] s_data;
  logic s_valid, s_last, s_ready;
  logic write_enable;
  logic [7:0] write_address;
  logic [127:0] cmd_in;
  logic busy, done, error;
`ifdef CMD_MEM_LOADER_CHECKSUM_EN
  logic [127:0] checksum;
`endif
  int checks = 0;
  int failures = 0;
  int stalls = 0;
  logic [135:0] sb[$];

  cmd_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_cmds(num_cmds),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .write_enable(write_enable), .write_address(write_address), .cmd_in(cmd_in),
    .busy(busy), .done(done), .error(error)
`ifdef CMD_MEM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (write_enable) begin
      if (sb.size() == 0) chk("unexpected_write", {128'h0, write_address}, 136'h1ff);
      else begin
        logic [135:0] e;
        e = sb.pop_front();
        chk("wr_addr", 136'(write_address), 136'(e[135:128]));
        chk("wr_cmd", 136'(cmd_in), 136'(e[127:0]));
      end
    end

  task automatic run_load(input logic [7:0] base, input int n, input int nb, input int li,
                          input logic [31:0] d0, input bit gaps, input bit bstart);
    logic [127:0] a;
    int t;
    a = '0;
    for (int i = 0; i < nb; i++) begin
      a[(i%4)*32 +: 32] = d0 + 32'(i);
      if (i % 4 == 3 && (i == n*4-1 || i != li)) sb.push_back({8'(base + 8'(i/4)), a});
    end
    @(negedge clk);
    start = 1; base_addr = base; num_cmds = 9'(n);
    @(negedge clk);
    start = 0;
    chk("start_err_clr", 136'(error), 136'(0));
    chk("start_busy", 136'(busy), 136'(1));
    for (int i = 0; i < nb; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      s_data = d0 + 32'(i); s_last = (i == li); s_valid = 1;
      if (bstart && i == 2) begin start = 1; base_addr = 8'h99; num_cmds = 9'd1; end
      t = 0;
      while (!s_ready && t < 20) begin @(negedge clk); t++; stalls++; end
      if (t == 20) chk("ready_timeout", 136'(0), 136'(1));
      @(negedge clk);
      s_valid = 0; s_last = 0; start = 0;
    end
    chk("end_done", 136'(done), 136'(1));
    chk("end_error", 136'(error), 136'(li != n*4-1));
    chk("end_busy", 136'(busy), 136'(0));
    chk("end_ready", 136'(s_ready), 136'(0));
    chk("end_we", 136'(write_enable), 136'(nb == n*4));
    @(negedge clk);
    chk("done_pulse", 136'(done), 136'(0));
    chk("we_pulse", 136'(write_enable), 136'(0));
    chk("sb_empty", 136'(sb.size()), 136'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; start = 0; base_addr = 0; num_cmds = 0; s_data = 0; s_valid = 0; s_last = 0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {s_ready, write_enable, busy, done, error}, 136'(0));
    chk("rst_addr", 136'(write_address), 136'(0));
    chk("rst_cmd", 136'(cmd_in), 136'(0));
    rst_n = 1;
    @(negedge clk);
    // basic load
    run_load(8'h10, 2, 8, 7, 32'h1, 0, 0);
    chk("basic_cmd_hold", 136'(cmd_in), 136'(128'h00000008_00000007_00000006_00000005));
    chk("basic_addr_hold", 136'(write_address), 136'(8'h11));
`ifdef CMD_MEM_LOADER_CHECKSUM_EN
    chk("checksum", 136'(checksum), 136'(128'h0000000C_00000004_00000004_00000004));
`endif
    // wrap-around, gapless
    stalls = 0;
    run_load(8'hFE, 4, 16, 15, 32'hA000_0000, 0, 0);
    chk("wrap_no_stall", 136'(stalls), 136'(0));
    // random valid gaps
    run_load(8'h20, 3, 12, 11, 32'hB000_0000, 1, 0);
    // early s_last on beat 6, then a clean one-command load clears error
    run_load(8'h30, 3, 6, 5, 32'hC000_0000, 0, 0);
    run_load(8'h40, 1, 4, 3, 32'hD000_0000, 0, 0);
    // final beat without s_last
    run_load(8'h50, 1, 4, -1, 32'hE000_0000, 0, 0);
    // start while busy is ignored
    run_load(8'h60, 2, 8, 7, 32'hF000_0000, 0, 1);
    // zero-command load
    @(negedge clk);
    start = 1; base_addr = 8'h77; num_cmds = 0;
    @(negedge clk);
    start = 0;
    chk("zero_done", 136'(done), 136'(1));
    chk("zero_err", 136'(error), 136'(0));
    chk("zero_we", 136'(write_enable), 136'(0));
    chk("zero_busy", 136'(busy), 136'(0));
    @(negedge clk);
    chk("zero_done_pulse", 136'(done), 136'(0));
    // reset mid-load after beat 2
    start = 1; base_addr = 8'h70; num_cmds = 9'd1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 2; i++) begin
      s_data = 32'h5500 + 32'(i); s_valid = 1;
      @(negedge clk);
    end
    s_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_mid_busy", 136'(busy), 136'(0));
    chk("rst_mid_ready", 136'(s_ready), 136'(0));
    @(negedge clk);
    chk("rst_mid_we", 136'(write_enable), 136'(0));
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("rst_mid_idle", {busy, write_enable, done}, 136'(0));
    chk("rst_mid_sb", 136'(sb.size()), 136'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
